nibble_nor_seq: RTL and testbench

Serialising front-end and collector for the 4-bit `ls7402` NOR slice. It accepts a WIDTH-bit operand pair over a valid/ready handshake and presents one nibble pair per cycle to the slice, LSB nibble first. It gathers the slice's 4-bit results into a WIDTH-bit word and returns that word over a second valid/ready handshake. It sits between the datapath operand registers and the `ls7402` instance, so the CPU gets wide bitwise NOR from a single 4-bit gate package.

---
 rtl/nibble_nor_seq_pkg.sv | 12 +
 rtl/nibble_nor_seq_if.sv | 24 ++
 rtl/nibble_shreg.sv | 39 +++
 rtl/nibble_nor_seq.sv | 161 ++++++++++++++++
 tb/tb_nibble_nor_seq.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_nor_seq_pkg.sv
// Shared types and constants for the nibble-serial NOR sequencer.
package nibble_nor_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_nor_seq_if.sv
// Operand/result valid-ready bundle between the datapath and nibble_nor_seq.
interface nibble_nor_seq_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y
  );

endinterface

// File: rtl/nibble_shreg.sv
// WIDTH-bit register with parallel load and nibble right-shift inserting at the MSB end.
module nibble_shreg
  import nibble_nor_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [NIB_W-1:0] ins,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Load wins over shift; both are never requested together by the sequencer.
  always_comb begin
    q_d = q_q;
    if (load_en) begin
      q_d = load_val;
    end else if (shift_en) begin
      q_d = {ins, q_q[WIDTH-1:NIB_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/nibble_nor_seq.sv
// Serialises a WIDTH-bit operand pair through an external 4-bit NOR slice and reassembles the result.
// Optional NIBBLE_NOR_SEQ_ZERO_FLAG_EN adds the out_zero result flag.
module nibble_nor_seq
  import nibble_nor_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  nibble_nor_seq_if.slave  bus,
  output logic [NIB_W-1:0] nib_a,
  output logic [NIB_W-1:0] nib_b,
  input  logic [NIB_W-1:0] nib_y,
  output logic             busy
`ifdef NIBBLE_NOR_SEQ_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int unsigned NIBBLES = WIDTH / NIB_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             accept_c;
  logic             load_c;
  logic             shift_c;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             op_hi_unused;
`ifdef NIBBLE_NOR_SEQ_ZERO_FLAG_EN
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] res_nxt_c;
`endif

  assign accept_c = bus.in_valid & in_ready_q;

  // Operands shift in zeros, so their low nibble is already 0 whenever RUN is not active.
  nibble_shreg #(.WIDTH(WIDTH)) u_opa (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_c),
    .shift_en (shift_c),
    .load_val (bus.in_a),
    .ins      ({NIB_W{1'b0}}),
    .q        (opa)
  );

  nibble_shreg #(.WIDTH(WIDTH)) u_opb (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_c),
    .shift_en (shift_c),
    .load_val (bus.in_b),
    .ins      ({NIB_W{1'b0}}),
    .q        (opb)
  );

  nibble_shreg #(.WIDTH(WIDTH)) u_res (
    .clk      (clk),
    .rst      (rst),
    .load_en  (1'b0),
    .shift_en (shift_c),
    .load_val ({WIDTH{1'b0}}),
    .ins      (nib_y),
    .q        (res)
  );

  assign op_hi_unused = ^{opa[WIDTH-1:NIB_W], opb[WIDTH-1:NIB_W]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath control and next values of the registered outputs
  always_comb begin
    load_c      = 1'b0;
    shift_c     = 1'b0;
    idx_d       = idx_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
`ifdef NIBBLE_NOR_SEQ_ZERO_FLAG_EN
    res_nxt_c   = {nib_y, res[WIDTH-1:NIB_W]};
    zero_d      = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          load_c = 1'b1;
          idx_d  = '0;
        end
      end
      RUN: begin
        shift_c = 1'b1;
        if (idx_q != LAST_IDX) begin
          idx_d = idx_q + IDX_W'(1);
        end
`ifdef NIBBLE_NOR_SEQ_ZERO_FLAG_EN
        if (idx_q == LAST_IDX) begin
          zero_d = (res_nxt_c == '0);
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef NIBBLE_NOR_SEQ_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef NIBBLE_NOR_SEQ_ZERO_FLAG_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign nib_a         = opa[NIB_W-1:0];
  assign nib_b         = opb[NIB_W-1:0];
  assign busy          = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = res;
`ifdef NIBBLE_NOR_SEQ_ZERO_FLAG_EN
  assign out_zero      = zero_q;
`endif

endmodule

// File: tb/tb_nibble_nor_seq.sv
// Scoreboard bench for nibble_nor_seq at WIDTH=16 and WIDTH=8, with the NOR slice modelled inline.
module tb_nibble_nor_seq;

  localparam int unsigned W  = 16;
  localparam int unsigned W8 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_nor_seq_if #(.WIDTH(W))  bus  ();
  nibble_nor_seq_if #(.WIDTH(W8)) bus8 ();

  logic [3:0] nib_a, nib_b, nib_y;
  logic [3:0] nib_a8, nib_b8, nib_y8;
  logic       busy, busy8;
`ifdef NIBBLE_NOR_SEQ_ZERO_FLAG_EN
  logic       out_zero, out_zero8;
`endif

  // ls7402 stand-in: 4-bit NOR
  assign nib_y  = ~(nib_a | nib_b);
  assign nib_y8 = ~(nib_a8 | nib_b8);

  nibble_nor_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .nib_a (nib_a),
    .nib_b (nib_b),
    .nib_y (nib_y),
    .busy  (busy)
`ifdef NIBBLE_NOR_SEQ_ZERO_FLAG_EN
    ,
    .out_zero (out_zero)
`endif
  );

  nibble_nor_seq #(.WIDTH(W8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus8),
    .nib_a (nib_a8),
    .nib_b (nib_b8),
    .nib_y (nib_y8),
    .busy  (busy8)
`ifdef NIBBLE_NOR_SEQ_ZERO_FLAG_EN
    ,
    .out_zero (out_zero8)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc;
  logic [W-1:0]  exp_q[$];
  logic [W8-1:0] exp8_q[$];
  logic [3:0]    na[8];
  logic [3:0]    nb[8];
  int            ncnt;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] nor_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W / 4); i++) r[i*4 +: 4] = ~(a[i*4 +: 4] | b[i*4 +: 4]);
    return r;
  endfunction

  // Caller is at a negedge. Issues one op, pushes its expected result, collects the
  // nibble stream and compares the result on out_valid. Leaves the bench in DONE.
  task automatic issue_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, output int lat);
    logic [W-1:0] e;
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait got %b want 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    exp_q.push_back(exp);
    @(posedge clk);
    acc_cyc = cyc;
    lat  = 0;
    ncnt = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    while (!bus.out_valid && lat < 30) begin
      if (ncnt < 8) begin
        na[ncnt] = nib_a;
        nb[ncnt] = nib_b;
      end
      ncnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_timeout got %b want 1", bus.out_valid);
    end else if (bus.out_y !== e) begin
      errors++;
      $display("FAIL out_y a=%h b=%h got %h want %h", a, b, bus.out_y, e);
    end
  endtask

  // Completes the result handshake (out_ready high) and checks the return to IDLE.
  task automatic finish_op(input string tag);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got rdy=%b vld=%b busy=%b want 1 0 0", tag,
               bus.in_ready, bus.out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b want 1 0 0",
               bus.in_ready, bus.out_valid, busy);
    end
    checks++;
    if (bus.out_y !== 16'h0000 || nib_a !== 4'h0 || nib_b !== 4'h0) begin
      errors++;
      $display("FAIL reset_data got y=%h na=%h nb=%h want 0000 0 0", bus.out_y, nib_a, nib_b);
    end
  endtask

  task automatic test_basic();
    int lat;
    issue_op(16'h0000, 16'h0003, 16'hFFFC, lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL basic_latency got %0d want 4", lat);
    end
    finish_op("basic");
  endtask

  task automatic test_nibble_seq();
    int lat;
    logic [15:0] exp_na, exp_nb;
    exp_na = 16'h1234;
    exp_nb = 16'h00FF;
    issue_op(16'h1234, 16'h00FF, 16'hED00, lat);
    checks++;
    if (ncnt != 4) begin
      errors++;
      $display("FAIL seq_len got %0d want 4", ncnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (na[i] !== exp_na[i*4 +: 4] || nb[i] !== exp_nb[i*4 +: 4]) begin
        errors++;
        $display("FAIL seq_nib%0d got a=%h b=%h want a=%h b=%h", i, na[i], nb[i],
                 exp_na[i*4 +: 4], exp_nb[i*4 +: 4]);
      end
    end
    finish_op("seq");
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    issue_op(16'h1234, 16'h00FF, 16'hED00, lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'h0F0F;
      bus.in_b     = 16'h0000;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_y !== 16'hED00 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d got vld=%b y=%h rdy=%b busy=%b want 1 ed00 0 1", i,
                 bus.out_valid, bus.out_y, bus.in_ready, busy);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    finish_op("release");
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'hFFFF;
    bus.in_b     = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
        bus.out_y !== 16'h0000 || nib_a !== 4'h0) begin
      errors++;
      $display("FAIL midrst_state got rdy=%b vld=%b busy=%b y=%h na=%h want 1 0 0 0000 0",
               bus.in_ready, bus.out_valid, busy, bus.out_y, nib_a);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_valid got %0d valid cycles want 0", seen);
    end
    issue_op(16'hA0A0, 16'h0606, 16'h5959, lat);
    finish_op("midrst");
  endtask

  task automatic test_back_to_back();
    int lat;
    int prev;
    logic [W-1:0] a, b;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      issue_op(a, b, nor_model(a, b), lat);
      if (prev >= 0) begin
        checks++;
        if (acc_cyc - prev != 6) begin
          errors++;
          $display("FAIL b2b_interval got %0d want 6", acc_cyc - prev);
        end
      end
      prev = acc_cyc;
      finish_op("b2b");
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                     input logic exp_z);
    logic [7:0] e;
    int lat;
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.in_a     = a;
    bus8.in_b     = b;
    exp8_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = exp8_q.pop_front();
    checks++;
    if (bus8.out_valid !== 1'b1 || bus8.out_y !== e || lat != 2) begin
      errors++;
      $display("FAIL w8 a=%h b=%h got vld=%b y=%h lat=%0d want 1 %h 2", a, b,
               bus8.out_valid, bus8.out_y, lat, e);
    end
`ifdef NIBBLE_NOR_SEQ_ZERO_FLAG_EN
    checks++;
    if (out_zero8 !== exp_z) begin
      errors++;
      $display("FAIL w8_zero got %b want %b", out_zero8, exp_z);
    end
`else
    if (exp_z === 1'bx) $display("unexpected x");
`endif
    @(posedge clk);
  endtask

  task automatic test_width8();
    op8(8'hFF, 8'h00, 8'h00, 1'b1);
    op8(8'h0F, 8'h00, 8'hF0, 1'b0);
    op8(8'h5A, 8'h21, 8'h84, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nibble_seq();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
